// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A prescaler turns the system clock into a pixel clock-enable. Horizontal and
// vertical counters walk the raster (active, front porch, sync, back porch).
// col/row lead hsync/vsync/in_screen by LOOKAHEAD pixels through a short delay
// line, which hides the renderer's pipeline latency. Line/frame strobes and a
// completed-frame counter are also produced.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 0,
    parameter int CW        = 10,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               en,
    output logic               pix_ce,
    output logic [CW-1:0]      col,
    output logic [CW-1:0]      row,
    output logic               in_screen,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(V_TOTAL - 1);

    // Decoded raster flags, active-high: {de, hs, vs}.
    function automatic logic [2:0] decode_pos(input logic [CW-1:0] c, input logic [CW-1:0] r);
        logic de_v;
        logic hs_v;
        logic vs_v;
        de_v = (c < CW'(H_ACTIVE)) && (r < CW'(V_ACTIVE));
        hs_v = (c >= CW'(HS_START)) && (c < CW'(HS_END));
        vs_v = (r >= CW'(VS_START)) && (r < CW'(VS_END));
        return {de_v, hs_v, vs_v};
    endfunction

    logic [PW-1:0]      p_r;
    logic               pix_ce_s;
    logic [CW-1:0]      col_r;
    logic [CW-1:0]      row_r;
    logic [2:0]         cur_dec_s;
    logic [2:0]         out_dec_s;
    logic               line_start_r;
    logic               frame_start_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               col_wrap_s;
    logic               row_wrap_s;

    // Pixel enable fires on the last prescaler phase while running.
    always_comb begin
        pix_ce_s = 1'b0;
        if (en && (p_r == P_LAST)) begin
            pix_ce_s = 1'b1;
        end else begin
            pix_ce_s = 1'b0;
        end
    end

    assign col_wrap_s = (col_r == COL_LAST);
    assign row_wrap_s = (row_r == ROW_LAST);
    assign cur_dec_s  = decode_pos(col_r, row_r);

    // Prescaler: advances only while enabled so the pixel phase survives en gaps.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            p_r <= '0;
        end else if (en) begin
            if (p_r == P_LAST) begin
                p_r <= '0;
            end else begin
                p_r <= p_r + PW'(1);
            end
        end else begin
            p_r <= p_r;
        end
    end

    // Raster counters start at the last blanking position so the first pixel is (0,0).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            col_r <= COL_LAST;
            row_r <= ROW_LAST;
        end else if (pix_ce_s) begin
            if (col_wrap_s) begin
                col_r <= '0;
                if (row_wrap_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + CW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    generate
        if (LOOKAHEAD == 0) begin : g_no_delay
            assign out_dec_s = cur_dec_s;
        end else begin : g_delay
            logic [2:0] dly_r [LOOKAHEAD];

            // Delay line of decoded flags, stepped once per pixel.
            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    for (int i = 0; i < LOOKAHEAD; i++) begin
                        dly_r[i] <= 3'b000;
                    end
                end else if (pix_ce_s) begin
                    dly_r[0] <= cur_dec_s;
                    for (int i = 1; i < LOOKAHEAD; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end else begin
                    for (int i = 0; i < LOOKAHEAD; i++) begin
                        dly_r[i] <= dly_r[i];
                    end
                end
            end

            assign out_dec_s = dly_r[LOOKAHEAD-1];
        end
    endgenerate

    // Line/frame strobes and frame counter, updated on the wrapping pixel edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= '0;
        end else begin
            line_start_r  <= pix_ce_s & col_wrap_s;
            frame_start_r <= pix_ce_s & col_wrap_s & row_wrap_s;
            if (pix_ce_s && col_wrap_s && row_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign pix_ce      = pix_ce_s;
    assign col         = col_r;
    assign row         = row_r;
    assign in_screen   = out_dec_s[2];
    assign hsync       = out_dec_s[1] ? HS_POL : ~HS_POL;
    assign vsync       = out_dec_s[0] ? VS_POL : ~VS_POL;
    // Strobes are suppressed while the generator is paused.
    assign line_start  = line_start_r & en;
    assign frame_start = frame_start_r & en;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances, a pixel-event model
// feeding a scoreboard queue, plus directed checks on strobe spacing.
module tb_vga_timing_gen;

    typedef struct packed {
        int hact; int hfp; int hsw; int hbp;
        int vact; int vfp; int vsw; int vbp;
        int cd;   int hpol; int vpol; int la; int fw;
    } cfg_t;

    typedef struct packed {
        logic        pix_ce;
        logic [9:0]  col;
        logic [9:0]  row;
        logic        de;
        logic        hsync;
        logic        vsync;
        logic        ls;
        logic        fs;
        logic [15:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic clrn_a, clrn_b, en_a, en_b;

    logic       pix_ce_a, in_screen_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    logic [9:0] col_a, row_a;
    logic [1:0] frame_cnt_a;

    logic        pix_ce_b, in_screen_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [9:0]  col_b, row_b;
    logic [15:0] frame_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(0),
        .CW(10), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .clrn(clrn_a), .en(en_a), .pix_ce(pix_ce_a),
        .col(col_a), .row(row_a), .in_screen(in_screen_a),
        .hsync(hsync_a), .vsync(vsync_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b0), .LOOKAHEAD(3),
        .CW(10), .FRAME_W(16)
    ) dut_b (
        .clk(clk), .clrn(clrn_b), .en(en_b), .pix_ce(pix_ce_b),
        .col(col_b), .row(row_b), .in_screen(in_screen_b),
        .hsync(hsync_b), .vsync(vsync_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs from the number of pixel events since reset.
    function automatic exp_t model(input cfg_t c, input int pm, input int e, input bit lp, input bit en);
        exp_t x;
        int ht, vt, tot, idx, cc, rr, ed, idd, cd, rd;
        bit de, hs, vs;
        ht  = c.hact + c.hfp + c.hsw + c.hbp;
        vt  = c.vact + c.vfp + c.vsw + c.vbp;
        tot = ht * vt;
        idx = (e + tot - 1) % tot;
        cc  = idx % ht;
        rr  = idx / ht;
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        ed = e - c.la;
        if (ed >= 0) begin
            idd = (ed + tot - 1) % tot;
            cd  = idd % ht;
            rd  = idd / ht;
            de  = (cd < c.hact) && (rd < c.vact);
            hs  = (cd >= c.hact + c.hfp) && (cd < c.hact + c.hfp + c.hsw);
            vs  = (rd >= c.vact + c.vfp) && (rd < c.vact + c.vfp + c.vsw);
        end
        x.pix_ce = en && (pm == c.cd - 1);
        x.col    = 10'(cc);
        x.row    = 10'(rr);
        x.de     = de;
        x.hsync  = hs ? (c.hpol != 0) : (c.hpol == 0);
        x.vsync  = vs ? (c.vpol != 0) : (c.vpol == 0);
        x.ls     = en && lp && (cc == 0);
        x.fs     = en && lp && (idx == 0);
        x.fcnt   = 16'(((e + tot - 1) / tot) % (1 << c.fw));
        return x;
    endfunction

    task automatic cmp_out(input string p, input exp_t g, input exp_t x);
        check_val({p, "_pix_ce"},      32'(g.pix_ce), 32'(x.pix_ce));
        check_val({p, "_col"},         32'(g.col),    32'(x.col));
        check_val({p, "_row"},         32'(g.row),    32'(x.row));
        check_val({p, "_in_screen"},   32'(g.de),     32'(x.de));
        check_val({p, "_hsync"},       32'(g.hsync),  32'(x.hsync));
        check_val({p, "_vsync"},       32'(g.vsync),  32'(x.vsync));
        check_val({p, "_line_start"},  32'(g.ls),     32'(x.ls));
        check_val({p, "_frame_start"}, 32'(g.fs),     32'(x.fs));
        check_val({p, "_frame_cnt"},   32'(g.fcnt),   32'(x.fcnt));
    endtask

    exp_t q_a[$];
    exp_t q_b[$];

    initial begin
        cfg_t cfg_a, cfg_b;
        exp_t xa, xb, ga, gb;
        int   pm_a, e_a, pm_b, e_b;
        bit   lp_a, lp_b, pix;
        bit   prev_clrn_a, prev_clrn_b, wait_a, wait_b;
        int   rel_a, rel_b, last_ls_a, fs_seen_a, en_cnt_b;
        int   fseq [5] = '{1, 2, 3, 0, 1};

        cfg_a = '{hact:8, hfp:2, hsw:3, hbp:2, vact:4, vfp:1, vsw:2, vbp:1,
                  cd:1, hpol:1, vpol:1, la:0, fw:2};
        cfg_b = '{hact:8, hfp:2, hsw:3, hbp:2, vact:4, vfp:1, vsw:2, vbp:1,
                  cd:3, hpol:1, vpol:0, la:3, fw:16};

        clrn_a = 1'b0; clrn_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        pm_a = 0; e_a = 0; lp_a = 1'b0;
        pm_b = 0; e_b = 0; lp_b = 1'b0;
        prev_clrn_a = 1'b0; prev_clrn_b = 1'b0;
        wait_a = 1'b0; wait_b = 1'b0;
        rel_a = 0; rel_b = 0; last_ls_a = -1; fs_seen_a = 0; en_cnt_b = 0;

        for (cyc = 0; cyc < 1300; cyc++) begin
            @(negedge clk);
            // Stimulus for this cycle
            clrn_a = !((cyc < 3) || (cyc >= 560 && cyc < 562));
            clrn_b = !((cyc < 3) || (cyc >= 1000 && cyc < 1003));
            en_a   = !(cyc >= 700 && cyc < 705);
            if (cyc >= 200 && cyc < 207)
                en_b = 1'b0;
            else if (cyc >= 400 && cyc < 600)
                en_b = ($urandom_range(0, 3) != 0);
            else
                en_b = 1'b1;

            if (!clrn_a) begin pm_a = 0; e_a = 0; lp_a = 1'b0; last_ls_a = -1; end
            if (!clrn_b) begin pm_b = 0; e_b = 0; lp_b = 1'b0; en_cnt_b = 0; end
            if (clrn_a && !prev_clrn_a) begin rel_a = cyc; wait_a = 1'b1; end
            if (clrn_b && !prev_clrn_b) begin rel_b = cyc; wait_b = 1'b1; end
            prev_clrn_a = clrn_a;
            prev_clrn_b = clrn_b;

            q_a.push_back(model(cfg_a, pm_a, e_a, lp_a, en_a));
            q_b.push_back(model(cfg_b, pm_b, e_b, lp_b, en_b));

            #1;
            ga = '{pix_ce_a, col_a, row_a, in_screen_a, hsync_a, vsync_a,
                   line_start_a, frame_start_a, 16'(frame_cnt_a)};
            gb = '{pix_ce_b, col_b, row_b, in_screen_b, hsync_b, vsync_b,
                   line_start_b, frame_start_b, frame_cnt_b};
            xa = q_a.pop_front();
            xb = q_b.pop_front();
            cmp_out("a", ga, xa);
            cmp_out("b", gb, xb);

            // Directed: frame_cnt wraps 1,2,3,0,1 with a 2-bit counter
            if (frame_start_a && cyc < 560 && fs_seen_a < 5) begin
                check_val("a_fcnt_seq", 32'(frame_cnt_a), 32'(fseq[fs_seen_a]));
                fs_seen_a++;
            end
            // Directed: line_start every 15 clk while running freely
            if (line_start_a && cyc < 560) begin
                if (last_ls_a >= 0)
                    check_val("a_line_period", 32'(cyc - last_ls_a), 32'd15);
                last_ls_a = cyc;
            end
            // Directed: first frame_start lands in cycle CLK_DIV+1 after release
            if (wait_a && frame_start_a) begin
                check_val("a_first_fs", 32'(cyc - rel_a + 1), 32'd2);
                wait_a = 1'b0;
            end
            if (wait_b && frame_start_b) begin
                check_val("b_first_fs", 32'(cyc - rel_b + 1), 32'd4);
                wait_b = 1'b0;
            end
            // Directed: pix_ce spacing counted in enabled cycles is CLK_DIV
            if (clrn_b && en_b) en_cnt_b++;
            if (pix_ce_b) begin
                check_val("b_pix_spacing", 32'(en_cnt_b), 32'd3);
                en_cnt_b = 0;
            end

            // Advance the model across the coming clock edge
            if (clrn_a) begin
                pix = en_a && (pm_a == cfg_a.cd - 1);
                if (en_a) pm_a = (pm_a == cfg_a.cd - 1) ? 0 : pm_a + 1;
                if (pix) e_a++;
                lp_a = pix;
            end
            if (clrn_b) begin
                pix = en_b && (pm_b == cfg_b.cd - 1);
                if (en_b) pm_b = (pm_b == cfg_b.cd - 1) ? 0 : pm_b + 1;
                if (pix) e_b++;
                lp_b = pix;
            end
        end

        check_val("a_fs_pending", 32'(wait_a), 32'd0);
        check_val("b_fs_pending", 32'(wait_b), 32'd0);
        check_val("a_fs_seq_count", 32'(fs_seen_a), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
